// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: private HI/LO registers with a fixed-latency busy model.
// Results are computed at issue into shadow registers and committed on the last busy cycle.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        md_hazard,
  output logic [31:0] md_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
  localparam logic [3:0] OpMfhi  = 4'd7;
  localparam logic [3:0] OpMflo  = 4'd8;

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            wr_q, wr_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     hin_q, hin_d, lon_q, lon_d;

  // Multiplier: sign-extend for mult, zero-extend for multu; low 64 bits are the product.
  logic        mul_signed;
  logic [63:0] mul_a, mul_b, prod;
  assign mul_signed = (md_op == OpMult);
  assign mul_a      = {{32{rs_val[31] & mul_signed}}, rs_val};
  assign mul_b      = {{32{rt_val[31] & mul_signed}}, rt_val};
  assign prod       = mul_a * mul_b;

  // Divider on magnitudes; signs reapplied so the quotient truncates toward zero.
  logic        div_signed, rs_neg, rt_neg;
  logic [31:0] rs_mag, rt_mag, rt_safe, quo_mag, rem_mag, quo, rem;
  assign div_signed = (md_op == OpDiv);
  assign rs_neg     = div_signed & rs_val[31];
  assign rt_neg     = div_signed & rt_val[31];
  assign rs_mag     = rs_neg ? -rs_val : rs_val;
  assign rt_mag     = rt_neg ? -rt_val : rt_val;
  assign rt_safe    = (rt_val == 32'd0) ? 32'd1 : rt_mag;
  assign quo_mag    = rs_mag / rt_safe;
  assign rem_mag    = rs_mag % rt_safe;
  assign quo        = (rs_neg ^ rt_neg) ? -quo_mag : quo_mag;
  assign rem        = rs_neg ? -rem_mag : rem_mag;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hin_d   = hin_q;
    lon_d   = lon_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          case (md_op)
            OpMult, OpMultu: begin
              hin_d   = prod[63:32];
              lon_d   = prod[31:0];
              wr_d    = 1'b1;
              cnt_d   = CntW'(MULT_CYCLES);
              state_d = StMul;
            end
            OpDiv, OpDivu: begin
              hin_d   = rem;
              lon_d   = quo;
              wr_d    = (rt_val != 32'd0);
              cnt_d   = CntW'(DIV_CYCLES);
              state_d = StDiv;
            end
            OpMthi:  hi_d = rs_val;
            OpMtlo:  lo_d = rs_val;
            default: ;
          endcase
        end
      end
      StMul, StDiv: begin
        if (cnt_q == CntW'(1)) begin
          if (wr_q) begin
            hi_d = hin_q;
            lo_d = lon_q;
          end
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      wr_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      hin_q   <= '0;
      lon_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      wr_q    <= wr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hin_q   <= hin_d;
      lon_q   <= lon_d;
    end
  end

  assign busy      = busy_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign md_hazard = busy_q | (start & (md_op >= OpMult) & (md_op <= OpDivu));

  always_comb begin
    md_out = 32'd0;
    if (md_op == OpMfhi) md_out = hi_q;
    else if (md_op == OpMflo) md_out = lo_q;
  end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed corner cases plus randomized ops against a
// 64-bit arithmetic reference model of HI/LO.
module tb_e_mdu;

  localparam int MultN = 5;
  localparam int DivN  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        md_hazard;
  logic [31:0] md_out;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] mhi = 32'd0;
  logic [31:0] mlo = 32'd0;

  e_mdu #(
    .MULT_CYCLES(MultN),
    .DIV_CYCLES (DivN)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .busy     (busy),
    .md_hazard(md_hazard),
    .md_out   (md_out),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to have finished", $time);
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start  = 1'b0;
    md_op  = 4'd0;
    rs_val = 32'd0;
    rt_val = 32'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    md_op = 4'd8;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || md_out !== 32'd0 || md_hazard !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b hazard=%b hi=%h lo=%h md_out=%h, required all zero",
               busy, md_hazard, hi, lo, md_out);
    end
    md_op = 4'd0;
    mhi = 32'd0;
    mlo = 32'd0;
  endtask

  // Issues one mult/div in the current cycle and follows it through commit.
  task automatic test_muldiv(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    longint sa, sb, sq, sr;
    longint unsigned up;
    int n;
    eh = mhi;
    el = mlo;
    n  = (op == 4'd1 || op == 4'd2) ? MultN : DivN;
    case (op)
      4'd1: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sq = sa * sb;
        eh = sq[63:32];
        el = sq[31:0];
      end
      4'd2: begin
        up = longint'(a) * longint'(b);
        eh = up[63:32];
        el = up[31:0];
      end
      4'd3: if (b != 32'd0) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sq = sa / sb;
        sr = sa % sb;
        el = sq[31:0];
        eh = sr[31:0];
      end
      4'd4: if (b != 32'd0) begin
        el = a / b;
        eh = a % b;
      end
      default: ;
    endcase
    start  = 1'b1;
    md_op  = op;
    rs_val = a;
    rt_val = b;
    #1;
    checks++;
    if (md_hazard !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL issue_cycle op=%0d: hazard=%b busy=%b, required hazard=1 busy=0",
               op, md_hazard, busy);
    end
    next_cycle();
    idle_inputs();
    for (int i = 1; i <= n; i++) begin
      #1;
      checks++;
      if (busy !== 1'b1 || md_hazard !== 1'b1 || hi !== mhi || lo !== mlo) begin
        errors++;
        $display("FAIL busy_cycle op=%0d k=%0d: busy=%b hazard=%b hi=%h lo=%h, required 1 1 %h %h",
                 op, i, busy, md_hazard, hi, lo, mhi, mlo);
      end
      next_cycle();
    end
    checks++;
    if (busy !== 1'b0 || md_hazard !== 1'b0 || hi !== eh || lo !== el) begin
      errors++;
      $display("FAIL commit op=%0d a=%h b=%h: busy=%b hazard=%b hi=%h lo=%h, required 0 0 %h %h",
               op, a, b, busy, md_hazard, hi, lo, eh, el);
    end
    mhi = eh;
    mlo = el;
    md_op = 4'd7;
    #1;
    checks++;
    if (md_out !== mhi) begin
      errors++;
      $display("FAIL mfhi_read: md_out=%h, required %h", md_out, mhi);
    end
    md_op = 4'd8;
    #1;
    checks++;
    if (md_out !== mlo) begin
      errors++;
      $display("FAIL mflo_read: md_out=%h, required %h", md_out, mlo);
    end
    md_op = 4'd0;
  endtask

  task automatic test_directed();
    test_muldiv(4'd1, 32'hFFFF_FFFE, 32'd3);
    test_muldiv(4'd2, 32'hFFFF_FFFE, 32'd3);
    test_muldiv(4'd3, 32'hFFFF_FFF9, 32'd2);
    test_muldiv(4'd4, 32'd7, 32'd0);
    test_muldiv(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    test_muldiv(4'd3, 32'd7, 32'hFFFF_FFFE);
  endtask

  // Writes HI or LO in one cycle and reads it back through md_out in the next.
  task automatic move_and_read(input logic [3:0] op, input logic [31:0] v);
    start  = 1'b1;
    md_op  = op;
    rs_val = v;
    next_cycle();
    if (op == 4'd5) mhi = v;
    else mlo = v;
    md_op  = (op == 4'd5) ? 4'd7 : 4'd8;
    rs_val = 32'd0;
    #1;
    checks++;
    if (md_out !== v || busy !== 1'b0 || md_hazard !== 1'b0) begin
      errors++;
      $display("FAIL move_read op=%0d: md_out=%h busy=%b hazard=%b, required %h 0 0",
               op, md_out, busy, md_hazard, v);
    end
    idle_inputs();
  endtask

  task automatic test_move();
    move_and_read(4'd5, 32'h1234_5678);
    start  = 1'b1;
    md_op  = 4'd5;
    rs_val = 32'hCAFE_0001;
    next_cycle();
    md_op  = 4'd6;
    rs_val = 32'hCAFE_0002;
    next_cycle();
    idle_inputs();
    mhi = 32'hCAFE_0001;
    mlo = 32'hCAFE_0002;
    checks++;
    if (hi !== mhi || lo !== mlo) begin
      errors++;
      $display("FAIL back_to_back_move: hi=%h lo=%h, required %h %h", hi, lo, mhi, mlo);
    end
    // mtlo arriving mid-multiply must be dropped.
    start  = 1'b1;
    md_op  = 4'd2;
    rs_val = 32'd3;
    rt_val = 32'd5;
    next_cycle();
    md_op  = 4'd6;
    rs_val = 32'hDEAD_BEEF;
    rt_val = 32'd0;
    next_cycle();
    idle_inputs();
    checks++;
    if (lo !== mlo || busy !== 1'b1) begin
      errors++;
      $display("FAIL mtlo_while_busy: lo=%h busy=%b, required %h 1", lo, busy, mlo);
    end
    for (int i = 0; i < MultN - 1; i++) next_cycle();
    mhi = 32'd0;
    mlo = 32'd15;
    checks++;
    if (busy !== 1'b0 || hi !== mhi || lo !== mlo) begin
      errors++;
      $display("FAIL mult_after_dropped_mtlo: busy=%b hi=%h lo=%h, required 0 %h %h",
               busy, hi, lo, mhi, mlo);
    end
  endtask

  task automatic test_reset_mid();
    start  = 1'b1;
    md_op  = 4'd1;
    rs_val = 32'h0001_0000;
    rt_val = 32'h0001_0000;
    next_cycle();
    idle_inputs();
    next_cycle();
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    mhi = 32'd0;
    mlo = 32'd0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_op: busy=%b hi=%h lo=%h, required 0 0 0", busy, hi, lo);
    end
    test_muldiv(4'd4, 32'd100, 32'd7);
  endtask

  task automatic test_hazard_none();
    start  = 1'b1;
    md_op  = 4'd11;
    rs_val = 32'hFFFF_FFFF;
    rt_val = 32'd1;
    #1;
    checks++;
    if (md_hazard !== 1'b0 || md_out !== 32'd0) begin
      errors++;
      $display("FAIL op11_hazard: hazard=%b md_out=%h, required 0 0", md_hazard, md_out);
    end
    next_cycle();
    md_op = 4'd0;
    next_cycle();
    idle_inputs();
    checks++;
    if (busy !== 1'b0 || hi !== mhi || lo !== mlo) begin
      errors++;
      $display("FAIL noop_no_effect: busy=%b hi=%h lo=%h, required 0 %h %h", busy, hi, lo, mhi, mlo);
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(1, 6));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: b = 32'hFFFF_FFFF;
        3: a = 32'h8000_0000;
        default: ;
      endcase
      if (op >= 4'd5) move_and_read(op, a);
      else test_muldiv(op, a, b);
    end
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_directed();
    test_move();
    test_reset_mid();
    test_hazard_none();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
# e_mdu

Multiply/divide unit of the Execute stage. Executes mult, multu, div, divu, mthi, mtlo, mfhi and mflo against private HI/LO registers using a fixed-latency busy model. Its result feeds the EX/MEM register alongside the ALU result, and its busy/hazard outputs drive the stall logic that holds D-stage MDU instructions.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- start  in  1  a valid MDU instruction is in E this cycle (low for bubbles/flushed slots)
- md_op  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9–15 treated as none
- rs_val  in  32  forwarded rs operand (dividend / multiplicand / mthi-mtlo source)
- rt_val  in  32  forwarded rt operand (divisor / multiplier)
- busy  out  1  registered; high while an operation is in flight
- md_hazard  out  1  combinational: busy | (start & md_op∈{1..4})
- md_out  out  32  combinational: HI if md_op=7, LO if md_op=8, else 0
- hi  out  32  current HI register
- lo  out  32  current LO register

## Operation
- States: IDLE, MUL, DIV. The counter cnt has width sufficient for max(MULT_CYCLES, DIV_CYCLES).
- IDLE + start + mult/multu:
  - compute the 64-bit product (signed for mult, unsigned for multu) into shadow hi_n/lo_n;
  - cnt←MULT_CYCLES; go to MUL.
- IDLE + start + div/divu:
  - with a nonzero divisor, lo_n←quotient and hi_n←remainder;
  - cnt←DIV_CYCLES; go to DIV.
- Signed division truncates toward zero; the remainder takes the dividend's sign.
- 0x80000000 / 0xFFFFFFFF (signed) gives lo=0x80000000, hi=0.
- Divisor 0: the unit still goes busy for DIV_CYCLES, but HI/LO are left unchanged at commit.
- MUL/DIV: cnt decrements each cycle.
  - When cnt=1, the edge commits hi_n/lo_n to HI/LO, clears busy and returns to IDLE.
- start + mthi/mtlo with busy=0: HI (resp. LO)←rs_val at the next edge. No state change.
- start + any op while busy=1 is ignored, with no state or register change; the hazard unit guarantees this never happens legally.
- start with md_op=none/mfhi/mflo makes no state change. mfhi/mflo only read.
- reset, including mid-operation: state←IDLE, cnt←0, busy←0, HI←0, LO←0, and shadow results are discarded.

## Timing
- Reset values: busy=0, hi=0, lo=0, md_out=0 (with md_op=0), md_hazard=0 (with start=0).
- Mult/div start in cycle t:
  - busy=1 in cycles t+1 … t+N, where N=MULT_CYCLES or DIV_CYCLES;
  - HI/LO hold the new value from cycle t+N+1, when busy=0.
- md_hazard is high in cycle t (via start) and in t+1 … t+N (via busy), so a D-stage MDU instruction stalls for N+1 cycles total.
- A new mult/div is accepted in cycle t+N+1.
- mthi/mtlo in E at cycle t: a mfhi/mflo in E at t+1 reads the new value.
- md_out has zero latency. It reflects the committed HI/LO in the same cycle, so there is no bypass of an in-flight result; the stall rule makes one unnecessary.
- Back-to-back mthi then mtlo (t, t+1) both take effect.

## Test plan
- Reset then idle:
  - expect busy=0 and hi=lo=0;
  - mflo → md_out=0.
- mult with rs=0xFFFFFFFE (−2), rt=3 at t → busy high t+1..t+5, then hi=0xFFFFFFFF and lo=0xFFFFFFFA at t+6. The same operands with multu → hi=0x00000002, lo=0xFFFFFFFA.
- div with rs=0xFFFFFFF9 (−7), rt=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu with rs=7, rt=0 → busy 10 cycles, then hi/lo unchanged.
- Write/read ordering:
  - mthi 0x12345678 at t, mfhi at t+1 → md_out=0x12345678;
  - mtlo issued while busy → lo unchanged.
- Reset asserted at the 3rd busy cycle of a mult:
  - busy=0 and hi=lo=0 next cycle;
  - no commit occurs later;
  - a new div is accepted immediately.
- md_hazard:
  - high in the start cycle and all busy cycles, low in the cycle after commit;
  - start with md_op=11 → no effect and md_hazard=0.
